// File: rtl/pkt_fifo_pkg.sv
// Shared types for the MAC TX store-and-forward packet buffer.
package pkt_fifo_pkg;

  localparam int unsigned DATA_W_DEF  = 512;
  localparam int unsigned EMPTY_W_DEF = 6;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_W_DEF-1:0] empty;
  } pkt_beat_t;

  typedef enum logic {W_IDLE, W_PKT} wr_state_t;
  typedef enum logic {R_IDLE, R_PKT} rd_state_t;

endpackage

// File: rtl/pkt_sdp_ram.sv
// Simple dual-port beat RAM with a one-cycle registered read port.
module pkt_sdp_ram
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pkt_beat_t         wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output pkt_beat_t         rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  pkt_beat_t mem [DEPTH];

  // No reset on the array or read register so the RAM maps to block memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_tx_sf_fifo.sv
// Store-and-forward packet buffer feeding the MAC TX port, with cut-through
// fallback for packets larger than the buffer and CSR statistics.
module pkt_tx_sf_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned EMPTY_W = EMPTY_W_DEF,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [CNT_W-1:0]   stat_pkt_in,
  output logic [CNT_W-1:0]   stat_pkt_out,
  output logic [CNT_W-1:0]   stat_sop_err,
  output logic [CNT_W-1:0]   stat_cut_thru
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  wr_state_t        wr_state, wr_state_next;
  rd_state_t        rd_state, rd_state_next;
  logic [PTR_W-1:0] wptr, fptr, rptr, pkt_cnt, used, used_next;
  logic             wr_en, rd_en, take, wr_eop, rd_eop, full, fetch_empty;
  logic             sop_err, cut_start, rd_active;
  pkt_beat_t        wr_beat, rd_beat;

  // fptr fetches into the output register; rptr releases an entry only once
  // the MAC has taken the beat, so the presented beat still counts as used.
  assign wr_en       = in_valid & in_ready;
  assign take        = out_valid & out_ready;
  assign wr_eop      = wr_en & in_endofpacket;
  assign rd_eop      = take & out_endofpacket;
  assign used        = wptr - rptr;
  assign used_next   = used + PTR_W'(wr_en) - PTR_W'(take);
  assign full        = (used == PTR_W'(DEPTH));
  assign fetch_empty = (fptr == wptr);

  assign wr_beat = '{data: in_data, sop: in_startofpacket, eop: in_endofpacket, empty: in_empty};

  // Write FSM: tracks packet boundaries to flag a sop arriving mid-packet.
  always_comb begin
    wr_state_next = wr_state;
    sop_err       = 1'b0;
    if (wr_en) begin
      case (wr_state)
        W_IDLE: if (!in_endofpacket) wr_state_next = W_PKT;
        W_PKT: begin
          if (in_endofpacket)        wr_state_next = W_IDLE;
          else if (in_startofpacket) sop_err       = 1'b1;
        end
        default: wr_state_next = W_IDLE;
      endcase
    end
  end

  // Read FSM: start on a complete stored packet, or cut through when full.
  always_comb begin
    rd_state_next = rd_state;
    cut_start     = 1'b0;
    rd_active     = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (pkt_cnt != '0) begin
          rd_state_next = R_PKT;
          rd_active     = 1'b1;
        end else if (full) begin
          rd_state_next = R_PKT;
          rd_active     = 1'b1;
          cut_start     = 1'b1;
        end
      end
      R_PKT: begin
        rd_active = 1'b1;
        if (rd_eop) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Stop fetching once the eop beat is presented; the next packet waits for R_IDLE.
  assign rd_en = rd_active & ~fetch_empty & (~out_valid | out_ready)
               & ~(out_valid & out_endofpacket);

  pkt_sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (wr_beat),
    .re    (rd_en),
    .raddr (fptr[ADDR_W-1:0]),
    .rdata (rd_beat)
  );

  assign out_data          = rd_beat.data;
  assign out_startofpacket = rd_beat.sop;
  assign out_endofpacket   = rd_beat.eop;
  assign out_empty         = rd_beat.empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state      <= W_IDLE;
      rd_state      <= R_IDLE;
      wptr          <= '0;
      fptr          <= '0;
      rptr          <= '0;
      pkt_cnt       <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      stat_pkt_in   <= '0;
      stat_pkt_out  <= '0;
      stat_sop_err  <= '0;
      stat_cut_thru <= '0;
    end else begin
      wr_state      <= wr_state_next;
      rd_state      <= rd_state_next;
      wptr          <= wptr + PTR_W'(wr_en);
      fptr          <= fptr + PTR_W'(rd_en);
      rptr          <= rptr + PTR_W'(take);
      pkt_cnt       <= pkt_cnt + PTR_W'(wr_eop) - PTR_W'(rd_eop);
      in_ready      <= (used_next != PTR_W'(DEPTH));
      out_valid     <= rd_en | (out_valid & ~out_ready);
      stat_pkt_in   <= stat_pkt_in + CNT_W'(wr_eop);
      stat_pkt_out  <= stat_pkt_out + CNT_W'(rd_eop);
      stat_sop_err  <= stat_sop_err + CNT_W'(sop_err);
      stat_cut_thru <= stat_cut_thru + CNT_W'(cut_start);
    end
  end

endmodule

// File: tb/tb_pkt_tx_sf_fifo.sv
// Randomized and directed bench for pkt_tx_sf_fifo against an in-order beat
// queue model with packet-level bookkeeping.
module tb_pkt_tx_sf_fifo;
  import pkt_fifo_pkg::*;

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned EMPTY_W = 6;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned CW      = $bits(pkt_beat_t);

  logic               clk, rst_n;
  logic               in_valid, in_ready, in_sop, in_eop;
  logic [DATA_W-1:0]  in_data;
  logic [EMPTY_W-1:0] in_empty;
  logic               out_valid, out_ready, out_sop, out_eop;
  logic [DATA_W-1:0]  out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic [CNT_W-1:0]   stat_pkt_in, stat_pkt_out, stat_sop_err, stat_cut_thru;

  pkt_tx_sf_fifo #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
    .stat_pkt_in(stat_pkt_in), .stat_pkt_out(stat_pkt_out),
    .stat_sop_err(stat_sop_err), .stat_cut_thru(stat_cut_thru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted beat must emerge unchanged and in order.
  pkt_beat_t        exp_q[$];
  pkt_beat_t        mon_got, mon_exp;
  logic [CNT_W-1:0] m_pkt_in, m_pkt_out, m_sop_err;
  int               m_stored_eops, out_sops, out_eops;
  bit               m_in_pkt, sf_check, done;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pkt_in = '0; m_pkt_out = '0; m_sop_err = '0;
      m_stored_eops = 0; m_in_pkt = 1'b0;
    end else begin
      if (out_valid) check_eq("valid_nonempty", CW'(exp_q.size() != 0), CW'(1));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        mon_got = '{data: out_data, sop: out_sop, eop: out_eop, empty: out_empty};
        mon_exp = exp_q.pop_front();
        if (mon_exp.sop && sf_check) check_eq("sf_hold", CW'(m_stored_eops > 0), CW'(1));
        check_eq("beat", CW'(mon_got), CW'(mon_exp));
        if (mon_exp.sop) out_sops++;
        if (mon_exp.eop) begin out_eops++; m_pkt_out++; m_stored_eops--; end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty});
        if (m_in_pkt && in_sop && !in_eop) m_sop_err++;
        m_in_pkt = !in_eop;
        if (in_eop) begin m_pkt_in++; m_stored_eops++; end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic s, input logic e,
                           input logic [EMPTY_W-1:0] em);
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_valid = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check_eq("send_timeout", CW'(in_ready), CW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap_max, input bit bad_sop);
    int n;
    for (int i = 0; i < len; i++) begin
      send_beat(rand_data(), (i == 0) || (bad_sop && i == 1), i == len - 1,
                (i == len - 1) ? EMPTY_W'($urandom) : '0);
      n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (n > 0) begin repeat (n) @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check_eq("drain", CW'(exp_q.size()), CW'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_stats();
    check_eq("stat_pkt_in", CW'(stat_pkt_in), CW'(m_pkt_in));
    check_eq("stat_pkt_out", CW'(stat_pkt_out), CW'(m_pkt_out));
    check_eq("stat_sop_err", CW'(stat_sop_err), CW'(m_sop_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d1;
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; out_ready = 1'b0; sf_check = 1'b1; done = 1'b0;
    out_sops = 0; out_eops = 0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check_eq("rst_in_ready", CW'(in_ready), CW'(0));
    check_eq("rst_out_valid", CW'(out_valid), CW'(0));
    check_eq("rst_stats", CW'({stat_pkt_in, stat_pkt_out, stat_sop_err, stat_cut_thru}), CW'(0));
    rst_n = 1'b1;
    @(negedge clk); check_eq("rdy_pre_edge", CW'(in_ready), CW'(0));
    @(negedge clk); check_eq("rdy_post_edge", CW'(in_ready), CW'(1));
    @(posedge clk); #1;

    // Single-beat packet latency: valid two cycles after the eop write
    out_ready = 1'b1;
    d1 = rand_data();
    send_beat(d1, 1'b1, 1'b1, 6'd10);
    @(negedge clk); check_eq("t1_lat_n1", CW'(out_valid), CW'(0));
    @(negedge clk); check_eq("t1_lat_n2", CW'(out_valid), CW'(1));
    check_eq("t1_data", CW'(out_data), CW'(d1));
    check_eq("t1_empty", CW'(out_empty), CW'(10));
    @(posedge clk); #1;
    wait_drain(20);
    check_eq("t1_pkt_in", CW'(stat_pkt_in), CW'(1));
    check_eq("t1_pkt_out", CW'(stat_pkt_out), CW'(1));

    // 4-beat packet with input gaps: held until eop, then streamed without bubbles
    for (int i = 0; i < 4; i++) begin
      send_beat(rand_data(), i == 0, i == 3, (i == 3) ? 6'd3 : 6'd0);
      if (i < 3) begin
        @(negedge clk); check_eq("t2_hold", CW'(out_valid), CW'(0));
        @(posedge clk); @(posedge clk); #1;
      end
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_stream", CW'(out_valid), CW'(1));
      @(negedge clk);
    end
    check_eq("t2_end", CW'(out_valid), CW'(0));
    @(posedge clk); #1;
    wait_drain(20);

    // Fill to exactly 512 beats with the MAC stalled, then drain
    out_ready = 1'b0;
    for (int p = 0; p < 64; p++) send_pkt(8, 0, 1'b0);
    @(negedge clk);
    check_eq("t3_full", CW'(in_ready), CW'(0));
    check_eq("t3_head", CW'(out_valid), CW'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); check_eq("t3_rdy_hold", CW'(in_ready), CW'(0));
    @(negedge clk); check_eq("t3_rdy_back", CW'(in_ready), CW'(1));
    @(posedge clk); #1;
    wait_drain(2000);
    check_stats();

    // Oversize packet engages cut-through exactly once
    sf_check = 1'b0; out_sops = 0; out_eops = 0;
    send_pkt(600, 0, 1'b0);
    wait_drain(2000);
    sf_check = 1'b1;
    check_eq("t4_cut_thru", CW'(stat_cut_thru), CW'(1));
    check_eq("t4_one_sop", CW'(out_sops), CW'(1));
    check_eq("t4_one_eop", CW'(out_eops), CW'(1));

    // sop inside a packet is counted and forwarded unchanged
    send_pkt(3, 0, 1'b1);
    wait_drain(50);
    check_eq("t5_sop_err", CW'(stat_sop_err), CW'(1));

    // Random traffic with random backpressure
    fork
      begin
        for (int p = 0; p < 12; p++) send_pkt(int'($urandom_range(1, 20)), 2, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(2000);
    check_stats();
    check_eq("rand_cut_thru", CW'(stat_cut_thru), CW'(1));

    // Reset mid-packet with one complete packet stored
    out_ready = 1'b0;
    send_pkt(2, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(rand_data(), i == 0, 1'b0, 6'd0);
    @(negedge clk); check_eq("t6_pre_valid", CW'(out_valid), CW'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", CW'(out_valid), CW'(0));
    check_eq("t6_rst_ready", CW'(in_ready), CW'(0));
    check_eq("t6_rst_stats", CW'({stat_pkt_in, stat_pkt_out, stat_sop_err, stat_cut_thru}), CW'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_pkt(3, 1, 1'b0);
    wait_drain(50);
    check_stats();
    check_eq("t6_pkt_out", CW'(stat_pkt_out), CW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
